hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Hazard controller for the 5-stage MIPS pipeline; produces the flush (CLR) and stall controls consumed by the pipeline registers, primarily the CLR input of the ID/EX register.
- Consumes the register addresses and control bits that the ID/EX, EX/MEM and MEM/WB registers emit.
- Resolves load-use hazards, branch-compare hazards and forwarding selection.
- Tracks a multi-cycle multiply/divide unit (MDU) through a busy FSM that stalls dependent HI/LO accesses.

Parameters:
- MDU_LATENCY, 4, cycles the MDU needs after issue in EX before HI/LO are valid (legal range 2..15).
- CNT_W, 16, width of the optional performance counters.

Ports:
- CLK  in  1  pipeline clock; all state changes on the rising edge
- RST  in  1  asynchronous, active-high reset
- RsD, RtD  in  5  source registers of the instruction in Decode
- RsE, RtE  in  5  source registers of the instruction in Execute
- WriteRegE, WriteRegM, WriteRegW  in  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enable per stage
- MemtoRegE, MemtoRegM  in  1  load in EX / MEM
- BranchD  in  1  branch resolved in Decode
- MduStartD, MduStartE  in  1  MDU op in Decode / issued in Execute
- MfhiloD  in  1  mfhi/mflo in Decode
- StallF, StallD  out  1  hold the PC and IF/ID register
- FlushE  out  1  drives the ID/EX CLR (bubble insert)
- ForwardAE, ForwardBE  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- ForwardAD, ForwardBD  out  1  Decode branch comparator forward from MEM
- MduBusy  out  1  FSM in BUSY
- StallCount, FlushCount  out  CNT_W  optional performance counters (see Optional Feature)

Behaviour:
- Register $0 never creates a hazard or a forward. Every address match below also requires the address to be non-zero.
- Forwarding (combinational):
  - ForwardAE = 10 if RegWriteM and WriteRegM==RsE; else 01 if RegWriteW and WriteRegW==RsE; else 00. MEM has priority over WB.
  - ForwardBE is the same, using RtE.
  - ForwardAD = RegWriteM and WriteRegM==RsD. ForwardBD is the same, using RtD.
- lwstall = MemtoRegE and (RtE==RsD or RtE==RtD).
- brstall = BranchD and one of:
  - RegWriteE and WriteRegE in {RsD, RtD}, or
  - MemtoRegM and WriteRegM in {RsD, RtD}.
- MDU FSM, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE: if MduStartE, go to BUSY and set cnt = MDU_LATENCY-1.
  - BUSY: if cnt != 0, decrement cnt. If cnt == 0 and MduStartE, reload cnt (back-to-back issue). If cnt == 0 and no MduStartE, go to IDLE.
  - MduStartE while BUSY with cnt != 0 is a protocol violation. It reloads cnt; the bench flags it with an assertion.
- mdustall = (MfhiloD or MduStartD) and (MduStartE or (BUSY and cnt != 0)).
  - A dependent op directly behind an MDU issue therefore stalls exactly MDU_LATENCY cycles.
  - Decode may advance during the final BUSY cycle.
- stall = lwstall or brstall or mdustall. StallF = StallD = FlushE = stall, all combinational, with no added latency.
- MduBusy = (state == BUSY).
- Reset: state = IDLE, cnt = 0, counters = 0. With all inputs at zero, every output is 0.
- Reset asserted mid-BUSY aborts the MDU tracking immediately. The first cycle after release is IDLE.
- Simultaneous hazard sources simply OR together; each stalled cycle counts once.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - StallCount increments on each cycle with StallD = 1.
  - FlushCount increments on each rising edge of FlushE (0→1 transition, tracked with one register).
  - Both counters saturate at all-ones and clear on RST.
- Not defined: no counter logic is built; StallCount and FlushCount are tied to 0. The port list is unchanged.

Decomposition:
- Shared package hazard_pkg holds:
  - forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - MDU state encodings MDU_IDLE / MDU_BUSY;
  - MDU_CNT_W = 4.
- One sub-module, mdu_busy_tracker, holds the FSM and counter. Inputs: CLK, RST, MduStartE. Outputs: busy, last (cnt==0).

Test Plan:
- Load-use: MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for 1 cycle. With RtE=0 and RsD=0 → no stall.
- Forward priority: RsE=5, RegWriteM=1 with WriteRegM=5, RegWriteW=1 with WriteRegW=5 → ForwardAE=10. Drop RegWriteM → 01. WriteRegM=WriteRegW=0 → 00.
- Branch: BranchD=1, RsD=3, RegWriteE=1, WriteRegE=3 → 1 stall cycle. Next cycle the op is in MEM (RegWriteM=1, WriteRegM=3, MemtoRegM=0) → no stall, ForwardAD=1.
- MDU: MduStartE at t, MfhiloD=1 held, MDU_LATENCY=4 → stall high t..t+3, low at t+4. MduBusy high t+1..t+4.
- Back-to-back MDU: second MduStartE on the final BUSY cycle → cnt reloads to 3, MduBusy stays high with no gap. Assert RST mid-BUSY → MduBusy=0 at once and counters clear.
- With HAZARD_PERF_CNT_EN: 3 separate 1-cycle load-use stalls → StallCount=3, FlushCount=3. One 4-cycle MDU stall → StallCount +4, FlushCount +1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forward selects, MDU FSM states,
// MDU counter width and the non-zero register match helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int MDU_CNT_W = 4;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    // $0 is hardwired to zero, so it never participates in a hazard or forward
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline <-> hazard controller signal bundle; the pipeline side is the master,
// the hazard controller is the slave.
interface hazard_control_unit_if #(parameter int CNT_W = 16);

    logic [4:0]       RsD, RtD, RsE, RtE;
    logic [4:0]       WriteRegE, WriteRegM, WriteRegW;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE, MemtoRegM;
    logic             BranchD;
    logic             MduStartD, MduStartE;
    logic             MfhiloD;
    logic             StallF, StallD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             ForwardAD, ForwardBD;
    logic             MduBusy;
    logic [CNT_W-1:0] StallCount, FlushCount;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MduStartD, MduStartE, MfhiloD,
        input  StallF, StallD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MduBusy, StallCount, FlushCount
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MduStartD, MduStartE, MfhiloD,
        output StallF, StallD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MduBusy, StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_control_unit_mdu_busy_tracker.sv
// Tracks the multi-cycle multiply/divide unit so dependent HI/LO accesses in
// Decode can be held until the result is valid.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   MDU_IDLE | no MDU operation outstanding
//   MDU_BUSY | MDU operation in flight; cnt counts down to the valid cycle
module mdu_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic MduStartE,
    output logic busy,
    output logic last
);

    localparam logic [MDU_CNT_W-1:0] RELOAD = MDU_CNT_W'(MDU_LATENCY - 1);

    mdu_state_t           state;
    logic [MDU_CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= MDU_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (MduStartE) begin
                        state <= MDU_BUSY;
                        cnt   <= RELOAD;
                    end
                end
                MDU_BUSY: begin
                    // a new issue always restarts the count, back-to-back or not
                    if (MduStartE)
                        cnt <= RELOAD;
                    else if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else
                        state <= MDU_IDLE;
                end
                default: begin
                    state <= MDU_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == MDU_BUSY);
    assign last = (cnt == '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects plus the
// combined load-use / branch / MDU stall. Performance counters: HAZARD_PERF_CNT_EN.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input logic                  CLK,
    input logic                  RST,
    hazard_control_unit_if.slave hif
);

    logic mdu_busy, mdu_last;
    logic lwstall, brstall, mdustall, stall;

    mdu_busy_tracker #(.MDU_LATENCY(MDU_LATENCY)) u_mdu (
        .CLK       (CLK),
        .RST       (RST),
        .MduStartE (hif.MduStartE),
        .busy      (mdu_busy),
        .last      (mdu_last)
    );

    always_comb begin
        hif.ForwardAE = FWD_RF;
        if (hif.RegWriteM && reg_match(hif.WriteRegM, hif.RsE))
            hif.ForwardAE = FWD_MEM;
        else if (hif.RegWriteW && reg_match(hif.WriteRegW, hif.RsE))
            hif.ForwardAE = FWD_WB;

        hif.ForwardBE = FWD_RF;
        if (hif.RegWriteM && reg_match(hif.WriteRegM, hif.RtE))
            hif.ForwardBE = FWD_MEM;
        else if (hif.RegWriteW && reg_match(hif.WriteRegW, hif.RtE))
            hif.ForwardBE = FWD_WB;
    end

    assign hif.ForwardAD = hif.RegWriteM && reg_match(hif.WriteRegM, hif.RsD);
    assign hif.ForwardBD = hif.RegWriteM && reg_match(hif.WriteRegM, hif.RtD);

    assign lwstall = hif.MemtoRegE &&
                     (reg_match(hif.RtE, hif.RsD) || reg_match(hif.RtE, hif.RtD));

    assign brstall = hif.BranchD &&
                     ((hif.RegWriteE && (reg_match(hif.WriteRegE, hif.RsD) ||
                                         reg_match(hif.WriteRegE, hif.RtD))) ||
                      (hif.MemtoRegM && (reg_match(hif.WriteRegM, hif.RsD) ||
                                         reg_match(hif.WriteRegM, hif.RtD))));

    // Decode may advance on the final BUSY cycle, when the count has reached zero
    assign mdustall = (hif.MfhiloD || hif.MduStartD) &&
                      (hif.MduStartE || (mdu_busy && !mdu_last));

    assign stall      = lwstall || brstall || mdustall;
    assign hif.StallF = stall;
    assign hif.StallD = stall;
    assign hif.FlushE = stall;
    assign hif.MduBusy = mdu_busy;

`ifdef HAZARD_PERF_CNT_EN
    logic             flush_q;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush_q   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            flush_q <= stall;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (stall && !flush_q && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign hif.StallCount = stall_cnt;
    assign hif.FlushCount = flush_cnt;
`else
    assign hif.StallCount = '0;
    assign hif.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: expected outputs are queued as each
// cycle's inputs are driven and compared on the following falling edge.
module tb_hazard_control_unit;

    localparam int CNT_W = 16;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    hazard_control_unit_if #(.CNT_W(CNT_W)) hif ();

    hazard_control_unit #(.MDU_LATENCY(4), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .hif (hif)
    );

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".StallF"},    32'(hif.StallF),    32'(e.stall));
            check({e.tag, ".StallD"},    32'(hif.StallD),    32'(e.stall));
            check({e.tag, ".FlushE"},    32'(hif.FlushE),    32'(e.stall));
            check({e.tag, ".ForwardAE"}, 32'(hif.ForwardAE), 32'(e.fae));
            check({e.tag, ".ForwardBE"}, 32'(hif.ForwardBE), 32'(e.fbe));
            check({e.tag, ".ForwardAD"}, 32'(hif.ForwardAD), 32'(e.fad));
            check({e.tag, ".ForwardBD"}, 32'(hif.ForwardBD), 32'(e.fbd));
            check({e.tag, ".MduBusy"},   32'(hif.MduBusy),   32'(e.busy));
        end
    end

    // issuing into the MDU while it still counts down is a pipeline protocol error
    always @(posedge CLK) begin
        if (!RST)
            assert (!(hif.MduBusy && !dut.mdu_last && hif.MduStartE))
            else $error("MduStartE issued while MDU busy");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic zero_in();
        hif.RsD = 5'd0;       hif.RtD = 5'd0;
        hif.RsE = 5'd0;       hif.RtE = 5'd0;
        hif.WriteRegE = 5'd0; hif.WriteRegM = 5'd0; hif.WriteRegW = 5'd0;
        hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
        hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
        hif.BranchD = 1'b0;
        hif.MduStartD = 1'b0; hif.MduStartE = 1'b0;
        hif.MfhiloD = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic stall, input logic [1:0] fae,
                              input logic [1:0] fbe, input logic fad, input logic fbd,
                              input logic busy);
        exp_t e;
        e.tag = tag; e.stall = stall; e.fae = fae; e.fbe = fbe;
        e.fad = fad; e.fbd = fbd; e.busy = busy;
        exp_q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic check_counters(input string tag, input int stall_n, input int flush_n);
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".StallCount"}, 32'(hif.StallCount), 32'(stall_n));
        check({tag, ".FlushCount"}, 32'(hif.FlushCount), 32'(flush_n));
`else
        check({tag, ".StallCount"}, 32'(hif.StallCount), 32'd0);
        check({tag, ".FlushCount"}, 32'(hif.FlushCount), 32'd0);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST = 1'b1;
        zero_in();

        cyc(); zero_in(); expect_out("reset", 0, 2'b00, 2'b00, 0, 0, 0);
        check_counters("reset", 0, 0);
        #2 RST = 1'b0;

        // three separate load-use stalls plus a $0 non-hazard
        cyc(); zero_in(); hif.MemtoRegE = 1; hif.RtE = 5'd8; hif.RsD = 5'd8;
        expect_out("lu_rs", 1, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); expect_out("lu_rs_gone", 0, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.MemtoRegE = 1; hif.RtE = 5'd0; hif.RsD = 5'd0;
        expect_out("lu_r0", 0, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.MemtoRegE = 1; hif.RtE = 5'd12; hif.RtD = 5'd12; hif.RsD = 5'd1;
        expect_out("lu_rt", 1, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.MemtoRegE = 0; hif.RtE = 5'd12; hif.RtD = 5'd12;
        expect_out("no_load", 0, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.MemtoRegE = 1; hif.RtE = 5'd20; hif.RsD = 5'd20;
        expect_out("lu_rs2", 1, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); expect_out("lu_done", 0, 2'b00, 2'b00, 0, 0, 0);
        check_counters("after_lu", 3, 3);

        // dependent mfhi directly behind an MDU issue
        cyc(); zero_in(); hif.MduStartE = 1; hif.MfhiloD = 1;
        expect_out("mdu_issue", 1, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("mdu_b3", 1, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("mdu_b2", 1, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("mdu_b1", 1, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("mdu_b0", 0, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); expect_out("mdu_idle", 0, 2'b00, 2'b00, 0, 0, 0);
        check_counters("after_mdu", 7, 4);

        // forwarding priority
        cyc(); zero_in(); hif.RsE = 5'd5; hif.RegWriteM = 1; hif.WriteRegM = 5'd5;
        hif.RegWriteW = 1; hif.WriteRegW = 5'd5;
        expect_out("fwd_mem", 0, 2'b10, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.RsE = 5'd5; hif.WriteRegM = 5'd5;
        hif.RegWriteW = 1; hif.WriteRegW = 5'd5;
        expect_out("fwd_wb", 0, 2'b01, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.RsE = 5'd0; hif.RtE = 5'd0; hif.RegWriteM = 1; hif.RegWriteW = 1;
        expect_out("fwd_r0", 0, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.RtE = 5'd7; hif.RsE = 5'd6; hif.RegWriteW = 1; hif.WriteRegW = 5'd7;
        hif.RegWriteM = 1; hif.WriteRegM = 5'd6;
        expect_out("fwd_split", 0, 2'b10, 2'b01, 0, 0, 0);
        cyc(); zero_in(); hif.RtD = 5'd9; hif.RsD = 5'd4; hif.RegWriteM = 1; hif.WriteRegM = 5'd9;
        expect_out("fwd_bd", 0, 2'b00, 2'b00, 0, 1, 0);

        // branch compare hazards
        cyc(); zero_in(); hif.BranchD = 1; hif.RsD = 5'd3; hif.RegWriteE = 1; hif.WriteRegE = 5'd3;
        expect_out("br_ex", 1, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.BranchD = 1; hif.RsD = 5'd3; hif.RegWriteM = 1; hif.WriteRegM = 5'd3;
        expect_out("br_mem_fwd", 0, 2'b00, 2'b00, 1, 0, 0);
        cyc(); zero_in(); hif.BranchD = 1; hif.RtD = 5'd4; hif.RegWriteM = 1;
        hif.MemtoRegM = 1; hif.WriteRegM = 5'd4;
        expect_out("br_load_mem", 1, 2'b00, 2'b00, 0, 1, 0);
        cyc(); zero_in(); hif.BranchD = 1; hif.RsD = 5'd0; hif.RegWriteE = 1; hif.WriteRegE = 5'd0;
        expect_out("br_r0", 0, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); hif.RsD = 5'd3; hif.RegWriteE = 1; hif.WriteRegE = 5'd3;
        expect_out("no_branch", 0, 2'b00, 2'b00, 0, 0, 0);

        // back-to-back MDU issue on the final BUSY cycle, then reset mid-BUSY
        cyc(); zero_in(); hif.MduStartE = 1; expect_out("b2b_issue", 0, 2'b00, 2'b00, 0, 0, 0);
        cyc(); zero_in(); expect_out("b2b_c3", 0, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); expect_out("b2b_c2", 0, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); expect_out("b2b_c1", 0, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); hif.MduStartE = 1; expect_out("b2b_c0_issue", 0, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("b2b_reload", 1, 2'b00, 2'b00, 0, 0, 1);
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("b2b_c2b", 1, 2'b00, 2'b00, 0, 0, 1);
        #2 RST = 1'b1;
        #1;
        check("rst_mid_busy.MduBusy", 32'(hif.MduBusy), 32'd0);
        check("rst_mid_busy.StallD",  32'(hif.StallD),  32'd0);
        check_counters("rst_mid_busy", 0, 0);
        zero_in();
        #2 RST = 1'b0;
        cyc(); zero_in(); hif.MfhiloD = 1; expect_out("post_rst", 0, 2'b00, 2'b00, 0, 0, 0);

        cyc(); zero_in();
        @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
